mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide execute unit. Sits directly downstream of the register file: it consumes the two source operands read from the register file, computes the M-extension result over a fixed number of cycles, and drives the register file's write port (data, destination address, write strobe) on completion. One operation in flight at a time; the pipeline stalls on `busy`.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  accept an operation this cycle. Ignored unless the FSM is in IDLE.
- `funct3`  in  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a`  in  32  rs1 value; register-file `datasent1`.
- `op_b`  in  32  rs2 value; register-file `datasent2`.
- `rd_in`  in  5  destination register index.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  32  final value; drives register-file `data_received`. Holds until the next completion.
- `rd_out`  out  5  latched `rd_in`; drives register-file `write_add`.
- `write`  out  1  register-file write strobe: equals `done & (rd_out != 0)`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE → CALC when `start` is high.
  - CALC → FIX after exactly 32 iterations.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- On accept, latch `funct3`, `rd_in`, and operand signs.
  - Signed operand: MUL/MULH/DIV/REM take both operands as signed; MULHSU treats only `op_a` as signed. MUL's low word is sign-agnostic and is computed on magnitudes with the sign fix.
  - Latch absolute values of signed operands; latch raw values for unsigned ones. Clear a 6-bit iteration counter.
- Multiply: radix-2 shift-add on a 64-bit accumulator, one multiplier bit per CALC cycle.
  - Product sign = sign_a XOR sign_b (signed operands only).
  - FIX negates the 64-bit product (two's complement) when the sign is negative.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide: restoring division, 33-bit partial remainder, one quotient bit per CALC cycle.
  - FIX negates the quotient if sign_a XOR sign_b, and negates the remainder if sign_a (signed ops only).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases, resolved in FIX with the same fixed latency:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `op_a`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- `result` and `rd_out` are registered and update on entry to DONE. `done` and `write` are high only in DONE.
- `write` is suppressed for `rd_out` = 0, so x0 is never written.
- `start` while not IDLE is ignored. No queueing; operands are not re-sampled.
- Operands are captured at accept. Later changes to `op_a`/`op_b` have no effect.

## Timing
- Reset values: `busy` 0, `done` 0, `write` 0, `result` 0, `rd_out` 0, FSM in IDLE, internal registers 0.
- Reset mid-operation aborts the operation. No `done` or `write` is produced, and outputs take reset values in the cycle after `rst` is sampled.
- `rst` has priority over `start` in the same cycle.
- Latency: define cycle 0 as the cycle in which `start` is sampled high in IDLE.
  - `busy` is high in cycles 1–34.
  - CALC occupies cycles 1–32 and FIX cycle 33.
  - DONE is cycle 34: `done`/`write` are high and `result` is valid.
- Identical latency for all eight operations, including special cases.
- Earliest next accept: a new `start` is accepted in cycle 35 (IDLE). Throughput is one operation per 35 cycles.
- The register file writes on the falling edge of `clk`, so `result`/`rd_out`/`write` must be stable for the full DONE cycle. All three are registered outputs.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5 → `done` and `write` high only in cycle 34, `result` 0xFFFFFFEB, `rd_out` 5. `busy` high in cycles 1–34.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 % 7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - All complete in cycle 34.
- Control corner cases:
  - `start` pulsed again in cycles 5 and 34 with different operands → ignored; the first result is unchanged and only one `done` is produced.
  - rd=0 → `done` 1, `write` 0.
  - `rst` asserted in cycle 10 → `busy` 0 from cycle 11, no `done`. A new `start` in cycle 12 completes in cycle 46.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative RV32M multiply/divide execute unit. Radix-2
//                shift-add multiply and restoring divide, one bit per cycle,
//                with a fixed 35-cycle accept-to-accept cadence. Drives the
//                register-file write port (data, address, strobe) on DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            write
);

    // FSM encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // funct3 encodings that need special handling
    localparam logic [2:0] c_MUL    = 3'd0;
    localparam logic [2:0] c_MULH   = 3'd1;
    localparam logic [2:0] c_MULHSU = 3'd2;
    localparam logic [2:0] c_MULHU  = 3'd3;
    localparam logic [2:0] c_DIV    = 3'd4;
    localparam logic [2:0] c_DIVU   = 3'd5;
    localparam logic [2:0] c_REM    = 3'd6;
    localparam logic [2:0] c_REMU   = 3'd7;

    localparam logic [5:0] c_LAST_ITER = 6'(XLEN - 1);

    logic [1:0]        r_state;
    logic [5:0]        r_cnt;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_b_zero;
    logic              r_ovf;
    logic [XLEN-1:0]   r_raw_a;
    logic [XLEN-1:0]   r_abs_a;
    logic [XLEN-1:0]   r_abs_b;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;
    logic              r_done;
    logic              r_write;

    logic              w_signed_a;
    logic              w_signed_b;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_result;

    // Operand signedness and magnitudes at accept time
    always_comb begin
        w_signed_a = (funct3 == c_MUL) || (funct3 == c_MULH) || (funct3 == c_MULHSU) ||
                     (funct3 == c_DIV) || (funct3 == c_REM);
        w_signed_b = (funct3 == c_MUL) || (funct3 == c_MULH) ||
                     (funct3 == c_DIV) || (funct3 == c_REM);
        w_sign_a   = w_signed_a & op_a[XLEN-1];
        w_sign_b   = w_signed_b & op_b[XLEN-1];
        w_abs_a    = w_sign_a ? (-op_a) : op_a;
        w_abs_b    = w_sign_b ? (-op_b) : op_b;
    end

    // One multiply step and one restoring-divide step per CALC cycle.
    // w_shift is the 33-bit partial remainder; the stored remainder always
    // fits in 32 bits because it stays below the divisor.
    always_comb begin
        w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_abs_a} : '0);
        w_shift = {r_rem, r_quo[XLEN-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_abs_b};
    end

    // Sign correction and special-case resolution used in FIX
    always_comb begin
        w_prod = (r_sign_a ^ r_sign_b) ? (-r_acc) : r_acc;
        w_quo  = (r_sign_a ^ r_sign_b) ? (-r_quo) : r_quo;
        w_rem  = r_sign_a ? (-r_rem) : r_rem;
        w_fix_result = '0;
        case (r_op)
            c_MUL:                   w_fix_result = w_prod[XLEN-1:0];
            c_MULH, c_MULHSU, c_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
            c_DIV, c_DIVU: begin
                if (r_b_zero)   w_fix_result = '1;
                else if (r_ovf) w_fix_result = {1'b1, {(XLEN-1){1'b0}}};
                else            w_fix_result = w_quo;
            end
            c_REM, c_REMU: begin
                if (r_b_zero)   w_fix_result = r_raw_a;
                else if (r_ovf) w_fix_result = '0;
                else            w_fix_result = w_rem;
            end
            default:                 w_fix_result = '0;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_ovf    <= 1'b0;
            r_raw_a  <= '0;
            r_abs_a  <= '0;
            r_abs_b  <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
            r_rd_out <= '0;
            r_done   <= 1'b0;
            r_write  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state  <= c_CALC;
                        r_cnt    <= '0;
                        r_op     <= funct3;
                        r_rd     <= rd_in;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_b_zero <= (op_b == '0);
                        r_ovf    <= ((funct3 == c_DIV) || (funct3 == c_REM)) &&
                                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
                        r_raw_a  <= op_a;
                        r_abs_a  <= w_abs_a;
                        r_abs_b  <= w_abs_b;
                        r_acc    <= {{XLEN{1'b0}}, w_abs_b};
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                    end
                end
                c_CALC: begin
                    // Both datapaths step every cycle; FIX picks the one r_op needs
                    r_acc <= {w_sum, r_acc[XLEN-1:1]};
                    if (w_diff[XLEN+1]) begin
                        r_rem <= w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end else begin
                        r_rem <= w_diff[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST_ITER) r_state <= c_FIX;
                end
                c_FIX: begin
                    r_result <= w_fix_result;
                    r_rd_out <= r_rd;
                    r_done   <= 1'b1;
                    r_write  <= (r_rd != 5'd0);
                    r_state  <= c_DONE;
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_write <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != c_IDLE);
    assign done   = r_done;
    assign write  = r_write;
    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Self-checking bench for mul_div_unit: directed vector table,
//                control corner sequences and randomized operations checked
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        write;

    int checks;
    int errors;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    mul_div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .write  (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: RV32M semantics from plain arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Runs one operation starting at the current negedge (cycle 0) and
    // checks busy/done/write per cycle through cycle 35. With inject set,
    // extra start pulses with different operands land in cycles 5 and 34.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit inject,
                         input string name);
        int bad;
        bad    = 0;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy  !== (k <= 34))              bad++;
            if (done  !== (k == 34))              bad++;
            if (write !== ((k == 34) && rd != 0)) bad++;
            if (k == 34) begin
                chk({name, " result"}, result, exp);
                chk({name, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
            end
            if (k == 35) chk({name, " hold"}, result, exp);
            if (inject && (k == 5 || k == 34)) begin
                start  = 1'b1;
                funct3 = f + 3'd1;
                op_a   = $urandom;
                op_b   = $urandom;
                rd_in  = rd + 5'd1;
            end
        end
        start = 1'b0;
        chk({name, " timing"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rr;
        int          bad;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;

        tbl[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF};
        tbl[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14};
        tbl[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2};
        tbl[8]  = '{3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF};
        tbl[9]  = '{3'd7, 32'd5,         32'd0,         5'd10, 32'd5};
        tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
        tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0};
        tbl[12] = '{3'd0, 32'd3,         32'd4,         5'd0,  32'd12};
        tbl[13] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         5'd13, 32'hFFFF_FFFB};
        tbl[14] = '{3'd5, 32'd5,         32'd0,         5'd31, 32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy",   {31'd0, busy},   32'd0);
        chk("reset done",   {31'd0, done},   32'd0);
        chk("reset write",  {31'd0, write},  32'd0);
        chk("reset result", result,          32'd0);
        chk("reset rd_out", {27'd0, rd_out}, 32'd0);

        // Directed vectors, issued back to back (each accept lands in cycle 35)
        for (int i = 0; i < 15; i++)
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, 1'b0,
                  $sformatf("vec%0d", i));

        // Extra start pulses in cycles 5 and 34 must be ignored
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, "ignore_start");
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("no second done", 32'(bad), 32'd0);

        // Reset mid-operation in cycle 10
        bad    = 0;
        start  = 1'b1;
        funct3 = 3'd5;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        rd_in  = 5'd4;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) rst = 1'b1;
            if (k == 11) rst = 1'b0;
            if (done !== 1'b0 || write !== 1'b0) bad++;
        end
        chk("abort no done",   32'(bad),        32'd0);
        chk("abort busy",      {31'd0, busy},   32'd0);
        chk("abort result",    result,          32'd0);
        chk("abort rd_out",    {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        do_op(3'd5, 32'd1000, 32'd3, 5'd4, 32'd333, 1'b0, "after_abort");

        // Reset wins over start in the same cycle
        rst    = 1'b1;
        start  = 1'b1;
        funct3 = 3'd0;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst over start", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst over start idle", {31'd0, busy}, 32'd0);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'd0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            rr = 5'($urandom_range(0, 31));
            do_op(rf, ra, rb, rr, model(rf, ra, rb), 1'b0,
                  $sformatf("rand%0d f%0d a=%h b=%h", n, rf, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
